mole_field_ctrl: RTL and testbench



---
 rtl/mole_pkg.sv | 37 +++
 rtl/mole_hole_pick.sv | 22 ++
 rtl/mole_field_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mole_field_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole field controller: state encoding
// and the hole-selection helpers reused by single- and multi-mole variants.
package mole_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Widest field any variant supports; helpers return this many bits.
   localparam int MAX_HOLES = 16;

   // One-hot vector with bit idx set, limited to the first n holes.
   function automatic logic [MAX_HOLES-1:0] onehot(input int idx, input int n);
      logic [MAX_HOLES-1:0] v;
      v = '0;
      for (int i = 0; i < MAX_HOLES; i++) begin
         if ((i == idx) && (i < n)) begin
            v[i] = 1'b1;
         end
      end
      return v;
   endfunction

   // Reduce the random index onto the field and step past the previous hole
   // (wrapping) so the same hole never lights twice in a row.
   function automatic int next_hole(input int number, input int prev, input int n);
      int cand;
      cand = number % n;
      if (cand == prev) begin
         cand = (cand == n - 1) ? 0 : cand + 1;
      end
      return cand;
   endfunction

endpackage

// File: rtl/mole_hole_pick.sv
// Combinational hole selection: random index plus previous hole in, new hole
// index and its one-hot LED pattern out.
module mole_hole_pick
   import mole_pkg::*;
#(
   parameter int NUM_HOLES = 5,
   parameter int IDX_W     = 3,
   parameter int HOLE_W    = 3
) (
   input  logic [IDX_W-1:0]     i_number,
   input  logic [HOLE_W-1:0]    i_prevHole,
   output logic [HOLE_W-1:0]    o_hole,
   output logic [NUM_HOLES-1:0] o_holeOneHot
);

   // Anti-repeat selection and its LED pattern, both purely combinational.
   always_comb begin
      o_hole       = HOLE_W'(next_hole(int'(i_number), int'(i_prevHole), NUM_HOLES));
      o_holeOneHot = NUM_HOLES'(onehot(int'(o_hole), NUM_HOLES));
   end

endmodule

// File: rtl/mole_field_ctrl.sv
// Whack-a-mole field controller: lights one hole at a time for a programmable
// hold time, judges presses as hit or miss, blanks the field between moles
// and keeps a saturating per-game score. Every output is registered.
module mole_field_ctrl
   import mole_pkg::*;
#(
   parameter int NUM_HOLES  = 5,
   parameter int IDX_W      = 3,
   parameter int TIMER_W    = 8,
   parameter int GAP_CYCLES = 2,
   parameter int SCORE_W    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic [IDX_W-1:0]     number,
   input  logic [TIMER_W-1:0]   hold_time,
   input  logic [NUM_HOLES-1:0] buttons,
   output logic [NUM_HOLES-1:0] displayL,
   output logic                 hit,
   output logic                 miss,
   output logic [SCORE_W-1:0]   score,
   output logic                 busy
);

   localparam int HOLE_W = $clog2(NUM_HOLES);
   localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

   state_t               r_state;
   logic [HOLE_W-1:0]    r_prevHole;
   logic [TIMER_W-1:0]   r_timer;
   logic [GAP_W-1:0]     r_gap;
   logic [NUM_HOLES-1:0] r_display;
   logic                 r_hit;
   logic                 r_miss;
   logic [SCORE_W-1:0]   r_score;
   logic                 r_busy;

   state_t               w_stateNext;
   logic [HOLE_W-1:0]    w_prevHoleNext;
   logic [TIMER_W-1:0]   w_timerNext;
   logic [GAP_W-1:0]     w_gapNext;
   logic [NUM_HOLES-1:0] w_displayNext;
   logic                 w_hitNext;
   logic                 w_missNext;
   logic [SCORE_W-1:0]   w_scoreNext;
   logic                 w_busyNext;

   logic [HOLE_W-1:0]    w_hole;
   logic [NUM_HOLES-1:0] w_holeOneHot;
   logic [TIMER_W-1:0]   w_holdLoad;

   mole_hole_pick #(
      .NUM_HOLES (NUM_HOLES),
      .IDX_W     (IDX_W),
      .HOLE_W    (HOLE_W)
   ) u_holePick (
      .i_number     (number),
      .i_prevHole   (r_prevHole),
      .o_hole       (w_hole),
      .o_holeOneHot (w_holeOneHot)
   );

   // A zero hold time still shows the mole for one cycle.
   assign w_holdLoad = (hold_time == '0) ? TIMER_W'(1) : hold_time;

   // Next-state and next-output decisions; the press check compares against
   // the lit pattern itself, so multi-button presses can never count as hits.
   always_comb begin
      w_stateNext    = r_state;
      w_prevHoleNext = r_prevHole;
      w_timerNext    = r_timer;
      w_gapNext      = r_gap;
      w_displayNext  = r_display;
      w_hitNext      = 1'b0;
      w_missNext     = 1'b0;
      w_scoreNext    = r_score;

      case (r_state)
         IDLE: begin
            w_displayNext = '0;
            if (run) begin
               w_prevHoleNext = w_hole;
               w_displayNext  = w_holeOneHot;
               w_timerNext    = w_holdLoad;
               w_scoreNext    = '0;
               w_stateNext    = SHOW;
            end
         end

         SHOW: begin
            if (!run) begin
               w_displayNext = '0;
               w_stateNext   = IDLE;
            end else if (buttons == r_display) begin
               w_hitNext     = 1'b1;
               if (r_score != '1) begin
                  w_scoreNext = r_score + SCORE_W'(1);
               end
               w_displayNext = '0;
               w_gapNext     = GAP_W'(GAP_CYCLES);
               w_stateNext   = GAP;
            end else if (buttons != '0) begin
               w_missNext    = 1'b1;
               w_displayNext = '0;
               w_gapNext     = GAP_W'(GAP_CYCLES);
               w_stateNext   = GAP;
            end else if (r_timer == TIMER_W'(1)) begin
               w_missNext    = 1'b1;
               w_displayNext = '0;
               w_gapNext     = GAP_W'(GAP_CYCLES);
               w_stateNext   = GAP;
            end else begin
               w_timerNext = r_timer - TIMER_W'(1);
            end
         end

         GAP: begin
            w_displayNext = '0;
            if (!run) begin
               w_stateNext = IDLE;
            end else if (r_gap == GAP_W'(1)) begin
               w_prevHoleNext = w_hole;
               w_displayNext  = w_holeOneHot;
               w_timerNext    = w_holdLoad;
               w_stateNext    = SHOW;
            end else begin
               w_gapNext = r_gap - GAP_W'(1);
            end
         end

         default: begin
            w_displayNext = '0;
            w_stateNext   = IDLE;
         end
      endcase

      w_busyNext = (w_stateNext != IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_prevHole <= HOLE_W'(NUM_HOLES - 1);
         r_timer    <= '0;
         r_gap      <= '0;
         r_display  <= '0;
         r_hit      <= 1'b0;
         r_miss     <= 1'b0;
         r_score    <= '0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_prevHole <= w_prevHoleNext;
         r_timer    <= w_timerNext;
         r_gap      <= w_gapNext;
         r_display  <= w_displayNext;
         r_hit      <= w_hitNext;
         r_miss     <= w_missNext;
         r_score    <= w_scoreNext;
         r_busy     <= w_busyNext;
      end
   end

   assign displayL = r_display;
   assign hit      = r_hit;
   assign miss     = r_miss;
   assign score    = r_score;
   assign busy     = r_busy;

endmodule

// File: tb/tb_mole_field_ctrl.sv
// Self-checking bench for mole_field_ctrl: a game-level model predicts every
// output each cycle, with directed scenarios pinned by literal expectations
// followed by a long randomized run.
module tb_mole_field_ctrl;

   localparam int N    = 5;
   localparam int G    = 2;
   localparam int SMAX = 255;

   logic       clk = 1'b0;
   logic       reset;
   logic       run;
   logic [2:0] number;
   logic [7:0] holdTime;
   logic [4:0] buttons;
   logic [4:0] displayL;
   logic       hit;
   logic       miss;
   logic [7:0] score;
   logic       busy;

   int total = 0;
   int bad   = 0;
   bit cmpEnable = 1'b0;

   // Game model: mode 0 = no game, 1 = mole up, 2 = blank field.
   int mMode    = 0;
   int mHole    = N - 1;
   int mVisLeft = 0;
   int mGapLeft = 0;
   int mScore   = 0;
   int mDisplay = 0;
   int mHit     = 0;
   int mMiss    = 0;
   int mBusy    = 0;

   always #5 clk = ~clk;

   mole_field_ctrl #(
      .NUM_HOLES  (N),
      .IDX_W      (3),
      .TIMER_W    (8),
      .GAP_CYCLES (G),
      .SCORE_W    (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .run       (run),
      .number    (number),
      .hold_time (holdTime),
      .buttons   (buttons),
      .displayL  (displayL),
      .hit       (hit),
      .miss      (miss),
      .score     (score),
      .busy      (busy)
   );

   function automatic int modelPick(input int num, input int prev);
      int c;
      c = num % N;
      if (c == prev) c = (c + 1) % N;
      return c;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Inputs change on the falling edge; outputs are checked one edge later.
   task automatic applyStimulus(input logic rst, input logic runV, input logic [2:0] num,
                                input logic [7:0] ht, input logic [4:0] btn);
      reset    = rst;
      run      = runV;
      number   = num;
      holdTime = ht;
      buttons  = btn;
      @(negedge clk);
   endtask

   // Advance the game model on each rising edge using the inputs it sees.
   always begin
      @(posedge clk);
      if (reset) begin
         mMode  = 0;
         mHole  = N - 1;
         mScore = 0;
         mHit   = 0;
         mMiss  = 0;
      end else begin
         mHit  = 0;
         mMiss = 0;
         if (mMode == 0) begin
            if (run) begin
               mHole    = modelPick(int'(number), mHole);
               mVisLeft = (holdTime == 0) ? 1 : int'(holdTime);
               mScore   = 0;
               mMode    = 1;
            end
         end else if (!run) begin
            mMode = 0;
         end else if (mMode == 1) begin
            if (int'(buttons) == (1 << mHole)) begin
               mHit     = 1;
               mScore   = (mScore < SMAX) ? mScore + 1 : SMAX;
               mMode    = 2;
               mGapLeft = G;
            end else if (buttons != 0 || mVisLeft == 1) begin
               mMiss    = 1;
               mMode    = 2;
               mGapLeft = G;
            end else begin
               mVisLeft = mVisLeft - 1;
            end
         end else begin
            if (mGapLeft == 1) begin
               mHole    = modelPick(int'(number), mHole);
               mVisLeft = (holdTime == 0) ? 1 : int'(holdTime);
               mMode    = 1;
            end else begin
               mGapLeft = mGapLeft - 1;
            end
         end
      end
      mDisplay = (mMode == 1) ? (1 << mHole) : 0;
      mBusy    = (mMode != 0) ? 1 : 0;
   end

   // Compare every output against the model on each falling edge.
   always begin
      @(negedge clk);
      if (cmpEnable) begin
         checkOutput("displayL", int'(displayL), mDisplay);
         checkOutput("hit", int'(hit), mHit);
         checkOutput("miss", int'(miss), mMiss);
         checkOutput("score", int'(score), mScore);
         checkOutput("busy", int'(busy), mBusy);
         checkOutput("hitMissExclusive", int'(hit & miss), 0);
      end
   end

   // Directed scenarios, saturation run, then randomized play.
   initial begin
      logic [4:0] btn;
      int         guard;
      int         sel;

      applyStimulus(1'b1, 1'b0, 3'd0, 8'd4, 5'b0);
      cmpEnable = 1'b1;
      applyStimulus(1'b1, 1'b0, 3'd0, 8'd4, 5'b0);
      checkOutput("resetDisplay", int'(displayL), 0);
      checkOutput("resetBusy", int'(busy), 0);
      checkOutput("resetScore", int'(score), 0);

      applyStimulus(1'b0, 1'b1, 3'd7, 8'd4, 5'b0);
      checkOutput("firstHole", int'(displayL), 4);
      checkOutput("firstBusy", int'(busy), 1);
      repeat (3) begin
         applyStimulus(1'b0, 1'b1, 3'd0, 8'd4, 5'b0);
         checkOutput("holdVisible", int'(displayL), 4);
      end
      applyStimulus(1'b0, 1'b1, 3'd0, 8'd4, 5'b0);
      checkOutput("timeoutMiss", int'(miss), 1);
      checkOutput("timeoutBlank", int'(displayL), 0);
      applyStimulus(1'b0, 1'b1, 3'd0, 8'd4, 5'b0);
      checkOutput("gapBlank", int'(displayL), 0);
      applyStimulus(1'b0, 1'b1, 3'd2, 8'd4, 5'b0);
      checkOutput("antiRepeat", int'(displayL), 8);

      repeat (4) applyStimulus(1'b0, 1'b1, 3'd0, 8'd4, 5'b0);
      applyStimulus(1'b0, 1'b1, 3'd0, 8'd4, 5'b0);
      applyStimulus(1'b0, 1'b1, 3'd4, 8'd4, 5'b0);
      checkOutput("hole4", int'(displayL), 16);
      applyStimulus(1'b0, 1'b1, 3'd0, 8'd4, 5'b00001);
      checkOutput("wrongPressMiss", int'(miss), 1);
      applyStimulus(1'b0, 1'b1, 3'd0, 8'd4, 5'b0);
      applyStimulus(1'b0, 1'b1, 3'd4, 8'd4, 5'b0);
      checkOutput("wrapHole", int'(displayL), 1);

      applyStimulus(1'b0, 1'b1, 3'd0, 8'd4, 5'b00010);
      applyStimulus(1'b0, 1'b1, 3'd0, 8'd4, 5'b0);
      applyStimulus(1'b0, 1'b1, 3'd2, 8'd4, 5'b0);
      checkOutput("hole2Again", int'(displayL), 4);
      repeat (3) applyStimulus(1'b0, 1'b1, 3'd0, 8'd4, 5'b0);
      applyStimulus(1'b0, 1'b1, 3'd0, 8'd4, 5'b00100);
      checkOutput("lastCycleHit", int'(hit), 1);
      checkOutput("lastCycleNoMiss", int'(miss), 0);
      checkOutput("scoreOne", int'(score), 1);
      applyStimulus(1'b0, 1'b1, 3'd0, 8'd4, 5'b00100);
      checkOutput("gapPressNoHit", int'(hit), 0);
      applyStimulus(1'b0, 1'b1, 3'd1, 8'd4, 5'b00100);
      checkOutput("gapPressNoMiss", int'(miss), 0);
      checkOutput("hole1", int'(displayL), 2);

      applyStimulus(1'b0, 1'b1, 3'd0, 8'd4, 5'b00001);
      applyStimulus(1'b0, 1'b1, 3'd0, 8'd4, 5'b0);
      applyStimulus(1'b0, 1'b1, 3'd2, 8'd4, 5'b0);
      applyStimulus(1'b0, 1'b1, 3'd0, 8'd4, 5'b00110);
      checkOutput("multiPressMiss", int'(miss), 1);
      checkOutput("multiPressScore", int'(score), 1);

      applyStimulus(1'b0, 1'b1, 3'd0, 8'd4, 5'b0);
      applyStimulus(1'b0, 1'b1, 3'd0, 8'd4, 5'b0);
      applyStimulus(1'b0, 1'b0, 3'd0, 8'd4, 5'b00001);
      checkOutput("stopDisplay", int'(displayL), 0);
      checkOutput("stopBusy", int'(busy), 0);
      checkOutput("stopNoPulse", int'(hit | miss), 0);
      checkOutput("stopScoreHeld", int'(score), 1);
      applyStimulus(1'b0, 1'b1, 3'd3, 8'd4, 5'b0);
      checkOutput("restartScore", int'(score), 0);
      checkOutput("restartHole", int'(displayL), 8);

      applyStimulus(1'b1, 1'b1, 3'd3, 8'd4, 5'b0);
      checkOutput("midResetDisplay", int'(displayL), 0);
      checkOutput("midResetBusy", int'(busy), 0);
      applyStimulus(1'b0, 1'b1, 3'd0, 8'd0, 5'b0);
      checkOutput("zeroHoldShown", int'(displayL), 1);
      applyStimulus(1'b0, 1'b1, 3'd0, 8'd0, 5'b0);
      checkOutput("zeroHoldMiss", int'(miss), 1);
      checkOutput("zeroHoldGone", int'(displayL), 0);

      guard = 0;
      while (mScore < SMAX && guard < 2000) begin
         btn = (mMode == 1) ? 5'(1 << mHole) : 5'b0;
         applyStimulus(1'b0, 1'b1, 3'($urandom), 8'($urandom_range(0, 7)), btn);
         guard++;
      end
      checkOutput("saturateReached", (guard < 2000) ? 1 : 0, 1);
      repeat (12) begin
         btn = (mMode == 1) ? 5'(1 << mHole) : 5'b0;
         applyStimulus(1'b0, 1'b1, 3'($urandom), 8'($urandom_range(0, 7)), btn);
      end
      checkOutput("scoreSaturated", int'(score), 255);

      repeat (3000) begin
         sel = $urandom_range(0, 9);
         if (sel < 6)      btn = 5'b0;
         else if (sel < 8) btn = (mMode == 1) ? 5'(1 << mHole) : 5'($urandom);
         else              btn = 5'($urandom);
         applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) != 0),
                       3'($urandom), 8'($urandom_range(0, 7)), btn);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
